// File: rtl/link_pkg.sv
`default_nettype none
// ============================================================================
// Module   : link_pkg
// Brief    : Shared definitions for the four-phase req/ack byte link.
//            Used by both the link master and link slave FSMs.
// Revision : 1.0 - initial release
// ============================================================================
package link_pkg;

    localparam int c_LINK_DATA_W = 8;

    typedef enum logic [1:0] {
        LINK_IDLE  = 2'd0,
        LINK_DELAY = 2'd1,
        LINK_ACK   = 2'd2
    } link_state_t;

    typedef logic [c_LINK_DATA_W-1:0] link_byte_t;

endpackage
`default_nettype wire

// File: rtl/link_slave_fsm.sv
`default_nettype none
// ============================================================================
// Module   : link_slave_fsm
// Brief    : Receiving end of the req/ack byte link; fills a DEPTH-byte frame
//            buffer and back-pressures until the frame is consumed.
//            Optional XOR checksum enabled by defining LINK_SLAVE_CSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module link_slave_fsm
    import link_pkg::*;
#(
    parameter int DATA_W    = c_LINK_DATA_W,
    parameter int DEPTH     = 4,
    parameter int ACK_DELAY = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req,
    input  logic [DATA_W-1:0]        data,
    output logic                     ack,
    input  logic                     frame_clr,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH)-1:0] byte_cnt,
    output logic                     rx_done,
    output logic                     frame_valid,
    output logic [DATA_W-1:0]        csum
);

    localparam int                       c_ADDR_W   = $clog2(DEPTH);
    localparam logic [2:0]               c_DLY_LOAD = (ACK_DELAY == 0) ? 3'd0 : 3'(ACK_DELAY - 1);
    localparam logic [c_ADDR_W-1:0]      c_LAST     = c_ADDR_W'(DEPTH - 1);

    link_state_t         r_state;
    logic                r_ack;
    logic [2:0]          r_dly_cnt;
    logic [c_ADDR_W-1:0] r_byte_cnt;
    logic                r_rx_done;
    logic                r_frame_valid;
    logic [DATA_W-1:0]   r_buf [DEPTH];

    logic w_capture;
    logic w_complete;
    logic w_last;

    assign w_capture  = (r_state == LINK_IDLE) && req && !r_frame_valid;
    assign w_complete = (r_state == LINK_ACK) && !req;
    assign w_last     = (r_byte_cnt == c_LAST);

    // ack is a registered decode of the state, so it trails the ACK state by
    // one cycle and never sees a combinational path from req.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= LINK_IDLE;
            r_ack         <= 1'b0;
            r_dly_cnt     <= 3'd0;
            r_byte_cnt    <= '0;
            r_rx_done     <= 1'b0;
            r_frame_valid <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_ack     <= (r_state == LINK_ACK);
            r_rx_done <= 1'b0;

            if (frame_clr && r_frame_valid) begin
                r_frame_valid <= 1'b0;
            end

            case (r_state)
                LINK_IDLE: begin
                    if (w_capture) begin
                        r_buf[r_byte_cnt] <= data;
                        if (ACK_DELAY == 0) begin
                            r_state <= LINK_ACK;
                        end else begin
                            r_state   <= LINK_DELAY;
                            r_dly_cnt <= c_DLY_LOAD;
                        end
                    end
                end
                LINK_DELAY: begin
                    // A req drop here abandons the byte; its slot is reused.
                    if (!req) begin
                        r_state <= LINK_IDLE;
                    end else if (r_dly_cnt == 3'd0) begin
                        r_state <= LINK_ACK;
                    end else begin
                        r_dly_cnt <= r_dly_cnt - 3'd1;
                    end
                end
                LINK_ACK: begin
                    if (w_complete) begin
                        r_state <= LINK_IDLE;
                        if (w_last) begin
                            r_byte_cnt    <= '0;
                            r_frame_valid <= 1'b1;
                            r_rx_done     <= 1'b1;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= LINK_IDLE;
                end
            endcase
        end
    end

`ifdef LINK_SLAVE_CSUM_EN
    logic [DATA_W-1:0] r_csum;

    // Accumulate on completion so an abandoned byte never enters the sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_csum <= '0;
        end else if (w_capture && (r_byte_cnt == '0)) begin
            r_csum <= '0;
        end else if (w_complete) begin
            r_csum <= r_csum ^ r_buf[r_byte_cnt];
        end
    end

    assign csum = r_csum;
`else
    assign csum = '0;
`endif

    assign ack         = r_ack;
    assign rd_data     = r_buf[rd_addr];
    assign byte_cnt    = r_byte_cnt;
    assign rx_done     = r_rx_done;
    assign frame_valid = r_frame_valid;

endmodule
`default_nettype wire

// File: tb/tb_link_slave_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_link_slave_fsm
// Brief    : Directed self-checking bench for link_slave_fsm with ACK_DELAY
//            of 0 and 3; honours LINK_SLAVE_CSUM_EN for checksum values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_link_slave_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       req0, req3;
    logic [7:0] data0, data3;
    logic       frame_clr0, frame_clr3;
    logic [1:0] rd_addr0, rd_addr3;

    logic       ack0, ack3;
    logic [7:0] rd_data0, rd_data3;
    logic [1:0] byte_cnt0, byte_cnt3;
    logic       rx_done0, rx_done3;
    logic       frame_valid0, frame_valid3;
    logic [7:0] csum0, csum3;

    int errors = 0;
    int checks = 0;
    int rxd_cnt0 = 0;

    link_slave_fsm #(.DATA_W(8), .DEPTH(4), .ACK_DELAY(0)) u_dut0 (
        .clk(clk), .rst(rst), .req(req0), .data(data0), .ack(ack0),
        .frame_clr(frame_clr0), .rd_addr(rd_addr0), .rd_data(rd_data0),
        .byte_cnt(byte_cnt0), .rx_done(rx_done0), .frame_valid(frame_valid0),
        .csum(csum0)
    );

    link_slave_fsm #(.DATA_W(8), .DEPTH(4), .ACK_DELAY(3)) u_dut3 (
        .clk(clk), .rst(rst), .req(req3), .data(data3), .ack(ack3),
        .frame_clr(frame_clr3), .rd_addr(rd_addr3), .rd_data(rd_data3),
        .byte_cnt(byte_cnt3), .rx_done(rx_done3), .frame_valid(frame_valid3),
        .csum(csum3)
    );

    always @(negedge clk) if (rx_done0) rxd_cnt0++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Acts as the link master: lat = edges from capture to ack seen high,
    // period = cycles from raising req to being ready for the next byte.
    task automatic send(input bit sel, input logic [7:0] b, input bit clr_on_done,
                        output int lat, output int period);
        int n;
        if (sel) begin req3 = 1'b1; data3 = b; end
        else     begin req0 = 1'b1; data0 = b; end
        lat = 0;
        do begin tick(); lat++; end while (!(sel ? ack3 : ack0) && lat < 40);
        period = lat;
        if (sel) req3 = 1'b0; else req0 = 1'b0;
        if (clr_on_done) frame_clr0 = 1'b1;
        n = 0;
        do begin
            tick(); n++;
            if (clr_on_done) frame_clr0 = 1'b0;
        end while ((sel ? ack3 : ack0) && n < 40);
        period += n;
        lat = lat - 1;
    endtask

    logic [7:0] frame1 [4];
    logic [7:0] exp_csum1, exp_csum2;
    int         lat, per, n;
    bit         seen;

    initial begin
        frame1[0] = 8'h12; frame1[1] = 8'h34; frame1[2] = 8'h56; frame1[3] = 8'h78;
`ifdef LINK_SLAVE_CSUM_EN
        exp_csum1 = 8'h08;
        exp_csum2 = 8'hA7;
`else
        exp_csum1 = 8'h00;
        exp_csum2 = 8'h00;
`endif
        rst = 1'b1;
        req0 = 1'b0; req3 = 1'b0; data0 = 8'h00; data3 = 8'h00;
        frame_clr0 = 1'b0; frame_clr3 = 1'b0; rd_addr0 = 2'd0; rd_addr3 = 2'd0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_ack", 32'(ack0), 32'd0);
        chk("rst_byte_cnt", 32'(byte_cnt0), 32'd0);
        chk("rst_frame_valid", 32'(frame_valid0), 32'd0);
        chk("rst_rx_done", 32'(rx_done0), 32'd0);
        chk("rst_csum", 32'(csum0), 32'd0);

        // Frame 1 with ACK_DELAY=0
        for (int i = 0; i < 4; i++) begin
            send(1'b0, frame1[i], 1'b0, lat, per);
            chk("d0_ack_lat", 32'(lat), 32'd1);
            chk("d0_period", 32'(per), 32'd4);
            chk("d0_byte_cnt", 32'(byte_cnt0), 32'((i + 1) % 4));
        end
        chk("f1_rx_done_cnt", 32'(rxd_cnt0), 32'd1);
        chk("f1_frame_valid", 32'(frame_valid0), 32'd1);
        for (int i = 0; i < 4; i++) begin
            rd_addr0 = 2'(i);
            #1;
            chk("f1_rd_data", 32'(rd_data0), 32'(frame1[i]));
        end
        chk("f1_csum", 32'(csum0), 32'(exp_csum1));

        // Back-pressure while the frame is unread
        req0 = 1'b1; data0 = 8'hA0; seen = 1'b0;
        repeat (6) begin tick(); if (ack0) seen = 1'b1; end
        chk("bp_no_ack", 32'(seen), 32'd0);
        rd_addr0 = 2'd0;
        #1;
        chk("bp_buf0", 32'(rd_data0), 32'h12);
        chk("bp_frame_valid", 32'(frame_valid0), 32'd1);
        frame_clr0 = 1'b1;
        tick();
        frame_clr0 = 1'b0;
        chk("clr_frame_valid", 32'(frame_valid0), 32'd0);
        send(1'b0, 8'hA0, 1'b0, lat, per);
        chk("bp_ack_lat", 32'(lat), 32'd1);
        chk("bp_buf0_new", 32'(rd_data0), 32'hA0);
        chk("bp_byte_cnt", 32'(byte_cnt0), 32'd1);

        // frame_clr coincident with completion: set wins
        send(1'b0, 8'h01, 1'b0, lat, per);
        send(1'b0, 8'h02, 1'b0, lat, per);
        send(1'b0, 8'h04, 1'b1, lat, per);
        chk("setwins_frame_valid", 32'(frame_valid0), 32'd1);
        chk("f2_rx_done_cnt", 32'(rxd_cnt0), 32'd2);
        chk("f2_csum", 32'(csum0), 32'(exp_csum2));
        frame_clr0 = 1'b1;
        tick();
        frame_clr0 = 1'b0;
        chk("f2_cleared", 32'(frame_valid0), 32'd0);

        // Reset while in ACK after two bytes
        send(1'b0, 8'h11, 1'b0, lat, per);
        send(1'b0, 8'h22, 1'b0, lat, per);
        chk("pre_rst_byte_cnt", 32'(byte_cnt0), 32'd2);
        req0 = 1'b1; data0 = 8'h33; n = 0;
        do begin tick(); n++; end while (!ack0 && n < 20);
        chk("pre_rst_ack", 32'(ack0), 32'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_ack", 32'(ack0), 32'd0);
        chk("mid_rst_byte_cnt", 32'(byte_cnt0), 32'd0);
        rst = 1'b0; req0 = 1'b0;
        tick();
        send(1'b0, 8'h44, 1'b0, lat, per);
        rd_addr0 = 2'd0;
        #1;
        chk("post_rst_buf0", 32'(rd_data0), 32'h44);
        chk("post_rst_byte_cnt", 32'(byte_cnt0), 32'd1);
        rd_addr0 = 2'd1;
        #1;
        chk("post_rst_buf1", 32'(rd_data0), 32'h00);

        // ACK_DELAY=3 timing
        send(1'b1, 8'h5A, 1'b0, lat, per);
        chk("d3_ack_lat", 32'(lat), 32'd4);
        chk("d3_period", 32'(per), 32'd7);
        chk("d3_byte_cnt", 32'(byte_cnt3), 32'd1);

        // req dropped during DELAY
        req3 = 1'b1; data3 = 8'h99;
        tick(); tick();
        req3 = 1'b0; seen = 1'b0;
        repeat (6) begin tick(); if (ack3) seen = 1'b1; end
        chk("abort_no_ack", 32'(seen), 32'd0);
        chk("abort_byte_cnt", 32'(byte_cnt3), 32'd1);
        send(1'b1, 8'h66, 1'b0, lat, per);
        chk("abort_next_lat", 32'(lat), 32'd4);
        rd_addr3 = 2'd1;
        #1;
        chk("abort_slot_reused", 32'(rd_data3), 32'h66);
        chk("abort_next_byte_cnt", 32'(byte_cnt3), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
`default_nettype wire
